// File: rtl/line_sensor_pkg.sv
// Shared definitions for the photodiode-line readout path: FSM encoding and
// default sample/line geometry also used by the SPI readout.
package line_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } line_state_t;

  localparam int LINE_ADC_W    = 12;
  localparam int LINE_N_PIXELS = 128;

endpackage

// File: rtl/line_pixel_outreg.sv
// One-entry valid/ready holding register for captured pixels; flags a sticky
// overrun when a new sample arrives while the held one cannot leave.
module line_pixel_outreg #(
  parameter int DATA_W = 12,
  parameter int IDX_W  = 7
) (
  input  logic              clk_10MHz_i,
  input  logic              reset_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic [IDX_W-1:0]  load_index,
  input  logic              clear_overrun,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic [IDX_W-1:0]  index,
  output logic              overrun
);

  logic              valid_reg;
  logic [DATA_W-1:0] data_reg;
  logic [IDX_W-1:0]  index_reg;
  logic              overrun_reg;
  logic              transfer;

  assign transfer = valid_reg & ready;

  always_ff @(posedge clk_10MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      index_reg   <= '0;
      overrun_reg <= 1'b0;
    end else begin
      // A slot frees up in the same cycle it transfers, so back-to-back loads need no gap.
      if (load && (!valid_reg || transfer)) begin
        valid_reg <= 1'b1;
        data_reg  <= load_data;
        index_reg <= load_index;
      end else if (transfer) begin
        valid_reg <= 1'b0;
      end

      if (clear_overrun) begin
        overrun_reg <= 1'b0;
      end else if (load && valid_reg && !transfer) begin
        overrun_reg <= 1'b1;
      end
    end
  end

  assign valid   = valid_reg;
  assign data    = data_reg;
  assign index   = index_reg;
  assign overrun = overrun_reg;

endmodule

// File: rtl/line_pixel_reader.sv
// Reads one sensor line after the falling edge of the start pulse: drives the
// pixel clock, samples the ADC per pixel and streams active pixels out.
module line_pixel_reader
  import line_sensor_pkg::*;
#(
  parameter int N_PIXELS = LINE_N_PIXELS,
  parameter int DUMMY    = 2,
  parameter int ADC_W    = LINE_ADC_W,
  parameter int CLK_DIV  = 4,
  parameter int SETTLE   = 2
) (
  input  logic                        clk_10MHz_i,
  input  logic                        reset_n,
  input  logic                        start_pulse_i,
  input  logic [ADC_W-1:0]            adc_data_i,
  output logic                        sensor_clk_o,
  output logic                        busy_o,
  output logic                        pix_valid_o,
  input  logic                        pix_ready_i,
  output logic [ADC_W-1:0]            pix_data_o,
  output logic [$clog2(N_PIXELS)-1:0] pix_index_o,
  output logic                        line_done_o,
  output logic                        overrun_o
);

  localparam int PH_W  = $clog2(CLK_DIV);
  localparam int K_W   = $clog2(DUMMY + N_PIXELS + 1);
  localparam int IDX_W = $clog2(N_PIXELS);

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_SAMP  = PH_W'(SETTLE);
  localparam logic [K_W-1:0]  K_LAST   = K_W'(DUMMY + N_PIXELS - 1);
  localparam logic [K_W-1:0]  K_DUMMY  = K_W'(DUMMY);

  line_state_t     state_reg, state_next;
  logic [PH_W-1:0] phase_reg, phase_next;
  logic [K_W-1:0]  pix_cnt_reg, pix_cnt_next;
  logic            start_prev_reg;
  logic            sensor_clk_reg;
  logic            busy_reg;
  logic            line_done_reg, line_done_next;

  logic            start_fall;
  logic            phase_end;
  logic            line_start;
  logic            capture;
  logic [IDX_W-1:0] capture_index;

  assign start_fall = start_prev_reg & ~start_pulse_i;
  assign phase_end  = (phase_reg == PH_LAST);

  always_ff @(posedge clk_10MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      phase_reg      <= '0;
      pix_cnt_reg    <= '0;
      start_prev_reg <= 1'b0;
      sensor_clk_reg <= 1'b0;
      busy_reg       <= 1'b0;
      line_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      pix_cnt_reg    <= pix_cnt_next;
      start_prev_reg <= start_pulse_i;
      // Pixel clock and busy follow the state being entered, so both change with the state register.
      sensor_clk_reg <= (state_next == HIGH);
      busy_reg       <= (state_next != IDLE);
      line_done_reg  <= line_done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    pix_cnt_next   = pix_cnt_reg;
    line_done_next = 1'b0;
    line_start     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start_fall) begin
          state_next   = HIGH;
          phase_next   = '0;
          pix_cnt_next = '0;
          line_start   = 1'b1;
        end
      end
      HIGH: begin
        if (phase_end) begin
          state_next = LOW;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      LOW: begin
        if (phase_end) begin
          phase_next = '0;
          if (pix_cnt_reg == K_LAST) begin
            state_next     = IDLE;
            pix_cnt_next   = '0;
            line_done_next = 1'b1;
          end else begin
            state_next   = HIGH;
            pix_cnt_next = pix_cnt_reg + 1'b1;
          end
        end else begin
          phase_next = phase_reg + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Leading dummy pixels are clocked but never sampled onto the stream.
  assign capture       = (state_reg == HIGH) && (phase_reg == PH_SAMP) && (pix_cnt_reg >= K_DUMMY);
  assign capture_index = IDX_W'(pix_cnt_reg - K_DUMMY);

  line_pixel_outreg #(
    .DATA_W (ADC_W),
    .IDX_W  (IDX_W)
  ) u_outreg (
    .clk_10MHz_i   (clk_10MHz_i),
    .reset_n       (reset_n),
    .load          (capture),
    .load_data     (adc_data_i),
    .load_index    (capture_index),
    .clear_overrun (line_start),
    .ready         (pix_ready_i),
    .valid         (pix_valid_o),
    .data          (pix_data_o),
    .index         (pix_index_o),
    .overrun       (overrun_o)
  );

  assign sensor_clk_o = sensor_clk_reg;
  assign busy_o       = busy_reg;
  assign line_done_o  = line_done_reg;

endmodule

// File: tb/tb_line_pixel_reader.sv
// Directed bench for line_pixel_reader with a 5-pixel (1 dummy + 4 active) line
// and a sensor clock of 2 high / 2 low cycles.
module tb_line_pixel_reader;

  localparam int N_PIXELS = 4;
  localparam int DUMMY    = 1;
  localparam int ADC_W    = 12;
  localparam int CLK_DIV  = 2;
  localparam int SETTLE   = 1;

  logic             clk_10MHz;
  logic             reset_n;
  logic             start_pulse;
  logic [ADC_W-1:0] adc_data;
  logic             sensor_clk;
  logic             busy;
  logic             pix_valid;
  logic             pix_ready;
  logic [ADC_W-1:0] pix_data;
  logic [1:0]       pix_index;
  logic             line_done;
  logic             overrun;

  int tests;
  int errors;
  int cyc;
  int t0;

  line_pixel_reader #(
    .N_PIXELS (N_PIXELS),
    .DUMMY    (DUMMY),
    .ADC_W    (ADC_W),
    .CLK_DIV  (CLK_DIV),
    .SETTLE   (SETTLE)
  ) dut (
    .clk_10MHz_i   (clk_10MHz),
    .reset_n       (reset_n),
    .start_pulse_i (start_pulse),
    .adc_data_i    (adc_data),
    .sensor_clk_o  (sensor_clk),
    .busy_o        (busy),
    .pix_valid_o   (pix_valid),
    .pix_ready_i   (pix_ready),
    .pix_data_o    (pix_data),
    .pix_index_o   (pix_index),
    .line_done_o   (line_done),
    .overrun_o     (overrun)
  );

  initial begin
    clk_10MHz = 1'b0;
    forever #50 clk_10MHz = ~clk_10MHz;
  end

  always @(negedge clk_10MHz) begin
    if (reset_n && pix_valid && pix_ready)
      $display("[TB] cycle %0d pixel idx=%0d data=%03h", cyc, pix_index, pix_data);
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle T0+%0d)", tag, act, exp, cyc - t0);
    end
  endtask

  // Advance one clock; the ADC presents 0x100 + cycle number during each cycle.
  task automatic step();
    @(posedge clk_10MHz);
    #1;
    cyc++;
    adc_data = 12'(32'h100 + cyc);
  endtask

  task automatic wait_off(input int off);
    while (cyc < t0 + off) step();
  endtask

  task automatic make_edge();
    start_pulse = 1'b1;
    step();
    step();
    step();
    start_pulse = 1'b0;
    t0 = cyc;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_sclk"},  32'(sensor_clk), 0);
    check({tag, "_valid"}, 32'(pix_valid), 0);
    check({tag, "_data"},  32'(pix_data), 0);
    check({tag, "_index"}, 32'(pix_index), 0);
    check({tag, "_done"},  32'(line_done), 0);
    check({tag, "_ovr"},   32'(overrun), 0);
  endtask

  // Full-line timing with ready held high; glitch>0 pulses start low again at T0+glitch.
  task automatic nominal_line(input int glitch);
    bit exp_valid;
    for (int off = 1; off <= 21; off++) begin
      wait_off(off);
      if (glitch > 0 && off == glitch - 1) start_pulse = 1'b1;
      if (glitch > 0 && off == glitch) start_pulse = 1'b0;
      exp_valid = (off >= 7) && (off <= 19) && (((off - 7) % 4) == 0);
      check("busy", 32'(busy), 32'(off <= 20));
      check("sclk", 32'(sensor_clk), 32'((off <= 20) && (((off - 1) % 4) < 2)));
      check("done", 32'(line_done), 32'(off == 21));
      check("valid", 32'(pix_valid), 32'(exp_valid));
      check("ovr", 32'(overrun), 0);
      if (exp_valid) begin
        check("index", 32'(pix_index), 32'((off - 7) / 4));
        check("data", 32'(pix_data), 32'(32'h100 + t0 + off - 1));
      end
    end
    start_pulse = 1'b0;
  endtask

  initial begin
    tests       = 0;
    errors      = 0;
    cyc         = 0;
    t0          = 0;
    reset_n     = 1'b0;
    start_pulse = 1'b0;
    pix_ready   = 1'b1;
    adc_data    = '0;

    step();
    step();
    check_outputs_zero("reset");
    reset_n = 1'b1;
    step();
    step();
    check_outputs_zero("idle");

    // Test 1: nominal line
    make_edge();
    check("t0_busy", 32'(busy), 0);
    nominal_line(0);

    // Test 3: short backpressure, reload without gap
    make_edge();
    wait_off(7);
    pix_ready = 1'b0;
    check("bp_valid7", 32'(pix_valid), 1);
    check("bp_index7", 32'(pix_index), 0);
    wait_off(9);
    check("bp_valid9", 32'(pix_valid), 1);
    check("bp_index9", 32'(pix_index), 0);
    check("bp_data9", 32'(pix_data), 32'(32'h100 + t0 + 6));
    wait_off(10);
    pix_ready = 1'b1;
    check("bp_valid10", 32'(pix_valid), 1);
    check("bp_index10", 32'(pix_index), 0);
    wait_off(11);
    check("bp_valid11", 32'(pix_valid), 1);
    check("bp_index11", 32'(pix_index), 1);
    check("bp_data11", 32'(pix_data), 32'(32'h100 + t0 + 10));
    check("bp_ovr11", 32'(overrun), 0);
    wait_off(21);
    check("bp_done21", 32'(line_done), 1);
    check("bp_ovr21", 32'(overrun), 0);

    // Test 4: falling edge during the line is ignored
    make_edge();
    nominal_line(8);

    // Test 2: ready low for the whole line, then back-to-back line (test 6)
    pix_ready = 1'b0;
    make_edge();
    wait_off(7);
    check("ovl_valid7", 32'(pix_valid), 1);
    check("ovl_index7", 32'(pix_index), 0);
    wait_off(10);
    check("ovl_ovr10", 32'(overrun), 0);
    wait_off(11);
    check("ovl_ovr11", 32'(overrun), 1);
    check("ovl_index11", 32'(pix_index), 0);
    check("ovl_data11", 32'(pix_data), 32'(32'h100 + t0 + 6));
    wait_off(19);
    check("ovl_ovr19", 32'(overrun), 1);
    check("ovl_index19", 32'(pix_index), 0);
    check("ovl_data19", 32'(pix_data), 32'(32'h100 + t0 + 6));
    wait_off(21);
    check("ovl_done21", 32'(line_done), 1);
    check("ovl_pending21", 32'(pix_valid), 1);
    check("ovl_index21", 32'(pix_index), 0);
    pix_ready   = 1'b1;
    start_pulse = 1'b1;
    wait_off(22);
    start_pulse = 1'b0;
    check("ovl_valid22", 32'(pix_valid), 0);
    check("ovl_ovr22", 32'(overrun), 1);
    t0 = cyc;
    nominal_line(0);

    // Test 5: reset mid-line with a pending pixel
    make_edge();
    wait_off(7);
    pix_ready = 1'b0;
    wait_off(9);
    check("rst_busy9", 32'(busy), 1);
    check("rst_sclk9", 32'(sensor_clk), 1);
    check("rst_valid9", 32'(pix_valid), 1);
    reset_n = 1'b0;
    #1;
    check_outputs_zero("rst_async");
    step();
    check_outputs_zero("rst_hold");
    reset_n   = 1'b1;
    pix_ready = 1'b1;
    step();
    check_outputs_zero("rst_after");
    make_edge();
    nominal_line(0);

    step();
    step();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
